// File: rtl/serial_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_framer
// Description : Word-level frame builder for the 16-bit parallel input of
//               serial_send (CLKF domain). One word leaves on DOUT every
//               cycle: IDLE_WORD between frames, otherwise
//               SOF, header {~LEN,LEN}, LEN payload words, trailer.
//               A payload underrun replaces the missing word with ABORT_WORD
//               and ends the frame. At least MIN_GAP idle words separate the
//               end of one frame from the next SOF.
// Build option: define SERIAL_FRAMER_CRC_EN for a CRC-16-CCITT trailer
//               (poly 0x1021, init 0xFFFF, MSB first); otherwise the trailer
//               is the 16-bit modular sum of header and payload words.
// Ports       : CLKF, RSTXF (sync, active low)
//               START_VALID/START_READY/LEN     frame request handshake
//               DIN_VALID/DIN_READY/DIN         payload stream
//               DOUT                            registered output word
//               BUSY, FRAME_DONE, ERR_UNDERRUN  registered status
// Revision    : 1.0  initial release
// ============================================================================
module serial_framer #(
  parameter logic [15:0] IDLE_WORD  = 16'hBC50,
  parameter logic [15:0] SOF_WORD   = 16'hFB5A,
  parameter logic [15:0] ABORT_WORD = 16'hFEFE,
  parameter int unsigned MIN_GAP    = 4
) (
  input  logic        CLKF,
  input  logic        RSTXF,
  input  logic        START_VALID,
  output logic        START_READY,
  input  logic [7:0]  LEN,
  input  logic        DIN_VALID,
  output logic        DIN_READY,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        ERR_UNDERRUN
);

  // The state names the section that will be loaded into DOUT at the next
  // edge. SOF is emitted straight from IDLE on the handshake, and ABORT
  // straight from PAY on an underrun, so neither needs its own state.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;
  localparam logic [1:0] ST_TRL  = 2'd3;

  localparam logic [3:0] GAP_RELOAD = 4'(MIN_GAP);

`ifdef SERIAL_FRAMER_CRC_EN
  localparam logic [15:0] CHK_INIT = 16'hFFFF;
`else
  localparam logic [15:0] CHK_INIT = 16'h0000;
`endif

  // Fold one 16-bit word into the running check value.
  function automatic logic [15:0] chk_fold(input logic [15:0] acc, input logic [15:0] word);
`ifdef SERIAL_FRAMER_CRC_EN
    logic [15:0] c;
    logic        fb;
    c = acc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ word[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
`else
    return acc + word;
`endif
  endfunction

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [3:0]  gap;
  logic [7:0]  len_q;
  logic [7:0]  remain;
  logic [15:0] acc;

  logic        accept;
  logic [15:0] hdr_word;
  logic [15:0] dout_d;
  logic        busy_d;
  logic        done_d;
  logic        err_d;
  logic [3:0]  gap_d;
  logic [7:0]  len_d;
  logic [7:0]  remain_d;
  logic [15:0] acc_d;

  assign accept   = START_VALID && (state == ST_IDLE) && (gap == 4'd0);
  assign hdr_word = {~len_q, len_q};

  // State register
  always_ff @(posedge CLKF) begin
    if (!RSTXF) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_HDR;
      ST_HDR:  next_state = (len_q == 8'd0) ? ST_TRL : ST_PAY;
      ST_PAY: begin
        if (!DIN_VALID)             next_state = ST_IDLE;
        else if (remain == 8'd1)    next_state = ST_TRL;
      end
      ST_TRL:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic: handshake strobes plus the values the datapath registers
  // load at the next edge.
  always_comb begin
    START_READY = (state == ST_IDLE) && (gap == 4'd0);
    DIN_READY   = (state == ST_PAY);
    dout_d      = IDLE_WORD;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    gap_d       = gap;
    len_d       = len_q;
    remain_d    = remain;
    acc_d       = acc;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          dout_d = SOF_WORD;
          busy_d = 1'b1;
          len_d  = LEN;
          acc_d  = CHK_INIT;
        end else if (gap != 4'd0) begin
          gap_d = gap - 4'd1;
        end
      end
      ST_HDR: begin
        dout_d   = hdr_word;
        busy_d   = 1'b1;
        acc_d    = chk_fold(acc, hdr_word);
        remain_d = len_q;
      end
      ST_PAY: begin
        busy_d = 1'b1;
        if (DIN_VALID) begin
          dout_d   = DIN;
          acc_d    = chk_fold(acc, DIN);
          remain_d = remain - 8'd1;
        end else begin
          dout_d = ABORT_WORD;
          err_d  = 1'b1;
          gap_d  = GAP_RELOAD;
        end
      end
      ST_TRL: begin
        dout_d = acc;
        busy_d = 1'b1;
        done_d = 1'b1;
        gap_d  = GAP_RELOAD;
      end
      default: ;
    endcase
  end

  // Datapath registers. Reset drops any frame in flight without a trailer.
  always_ff @(posedge CLKF) begin
    if (!RSTXF) begin
      DOUT         <= IDLE_WORD;
      BUSY         <= 1'b0;
      FRAME_DONE   <= 1'b0;
      ERR_UNDERRUN <= 1'b0;
      gap          <= GAP_RELOAD;
      len_q        <= 8'd0;
      remain       <= 8'd0;
      acc          <= 16'd0;
    end else begin
      DOUT         <= dout_d;
      BUSY         <= busy_d;
      FRAME_DONE   <= done_d;
      ERR_UNDERRUN <= err_d;
      gap          <= gap_d;
      len_q        <= len_d;
      remain       <= remain_d;
      acc          <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_framer
// Description : Self-checking bench for serial_framer. A word-position
//               reference model predicts every output word, pulse and ready
//               strobe; directed frames cover the documented examples and a
//               randomized run covers 100+ frames with underruns and resets.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_framer;

  localparam logic [15:0] IDLE_W  = 16'hBC50;
  localparam logic [15:0] SOF_W   = 16'hFB5A;
  localparam logic [15:0] ABORT_W = 16'hFEFE;
  localparam int          GAP     = 4;

  logic        CLKF = 1'b0;
  logic        RSTXF = 1'b0;
  logic        START_VALID = 1'b0;
  logic        START_READY;
  logic [7:0]  LEN = 8'd0;
  logic        DIN_VALID = 1'b0;
  logic        DIN_READY;
  logic [15:0] DIN = 16'd0;
  logic [15:0] DOUT;
  logic        BUSY;
  logic        FRAME_DONE;
  logic        ERR_UNDERRUN;

  always #5 CLKF = ~CLKF;

  serial_framer dut (
    .CLKF         (CLKF),
    .RSTXF        (RSTXF),
    .START_VALID  (START_VALID),
    .START_READY  (START_READY),
    .LEN          (LEN),
    .DIN_VALID    (DIN_VALID),
    .DIN_READY    (DIN_READY),
    .DIN          (DIN),
    .DOUT         (DOUT),
    .BUSY         (BUSY),
    .FRAME_DONE   (FRAME_DONE),
    .ERR_UNDERRUN (ERR_UNDERRUN)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_pos counts frame words already emitted (1 = SOF out, 2 = header out,
  // 2+k = k payload words out); trailer follows when m_pos == LEN+2.
  bit          m_known  = 0;
  bit          m_active = 0;
  int          m_pos    = 0;
  logic [7:0]  m_len    = 8'd0;
  logic [15:0] m_chk    = 16'd0;
  int          m_gap    = GAP;
  logic [15:0] e_dout;
  bit          e_busy, e_done, e_err;

  function automatic logic [15:0] ref_fold(input logic [15:0] acc, input logic [15:0] w);
`ifdef SERIAL_FRAMER_CRC_EN
    int unsigned c;
    int unsigned top;
    c = acc;
    for (int i = 15; i >= 0; i--) begin
      top = ((c >> 15) ^ (w >> i)) & 1;
      c   = (c << 1) & 32'hFFFF;
      if (top != 0) c = c ^ 32'h1021;
    end
    return c[15:0];
`else
    int unsigned s;
    s = (int'(acc) + int'(w)) % 65536;
    return s[15:0];
`endif
  endfunction

  function automatic logic [15:0] ref_init();
`ifdef SERIAL_FRAMER_CRC_EN
    return 16'hFFFF;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic bit m_start_ready();
    return !m_active && (m_gap == 0);
  endfunction

  function automatic bit m_din_ready();
    return m_active && (m_pos >= 2) && (m_pos <= int'(m_len) + 1);
  endfunction

  task automatic model_update(input logic rn, input bit go, input logic [7:0] ln,
                              input logic dv, input logic [15:0] d);
    logic [15:0] hdr;
    e_done = 0;
    e_err  = 0;
    if (!rn) begin
      m_known = 1; m_active = 0; m_pos = 0; m_gap = GAP;
      e_dout = IDLE_W; e_busy = 0;
    end else if (!m_active) begin
      if (go) begin
        m_active = 1; m_pos = 1; m_len = ln; m_chk = ref_init();
        e_dout = SOF_W; e_busy = 1;
      end else begin
        if (m_gap > 0) m_gap--;
        e_dout = IDLE_W; e_busy = 0;
      end
    end else if (m_pos == 1) begin
      hdr = {~m_len, m_len};
      m_chk = ref_fold(m_chk, hdr);
      m_pos = 2; e_dout = hdr; e_busy = 1;
    end else if (m_pos <= int'(m_len) + 1) begin
      e_busy = 1;
      if (dv) begin
        m_chk = ref_fold(m_chk, d);
        m_pos++; e_dout = d;
      end else begin
        e_dout = ABORT_W; e_err = 1;
        m_active = 0; m_pos = 0; m_gap = GAP;
      end
    end else begin
      e_dout = m_chk; e_busy = 1; e_done = 1;
      m_active = 0; m_pos = 0; m_gap = GAP;
    end
  endtask

  // One clock: drive at negedge, check readies, check registered outputs
  // 1 ns after the rising edge.
  task automatic step(input logic rn, input logic sv, input logic [7:0] ln,
                      input logic dv, input logic [15:0] d);
    bit rs, rd;
    @(negedge CLKF);
    RSTXF = rn; START_VALID = sv; LEN = ln; DIN_VALID = dv; DIN = d;
    rs = m_start_ready();
    rd = m_din_ready();
    #1;
    if (m_known && rn) begin
      check("start_ready", 16'(START_READY), 16'(rs));
      check("din_ready", 16'(DIN_READY), 16'(rd));
    end
    model_update(rn, sv && rs, ln, dv, d);
    @(posedge CLKF);
    #1;
    check("dout", DOUT, e_dout);
    check("busy", 16'(BUSY), 16'(e_busy));
    check("frame_done", 16'(FRAME_DONE), 16'(e_done));
    check("err_underrun", 16'(ERR_UNDERRUN), 16'(e_err));
  endtask

  // ---------------- directed frame driver ----------------
  logic [15:0] dlog[$];

  function automatic logic [15:0] logw(input int i);
    return (i < dlog.size()) ? dlog[i] : 16'hDEAD;
  endfunction

  // Requests a frame with START_VALID held high, streams payload words
  // first+k, drops DIN_VALID at payload index drop_at or pulls reset at
  // index rst_at (-1 = never). Returns the number of idle words seen before
  // SOF; the frame words observed on DOUT are collected in dlog.
  task automatic run_frame(input int len, input logic [15:0] first, input int drop_at,
                           input int rst_at, output int idles);
    bit started, fin;
    int idx;
    logic rn, dv;
    idles = 0; started = 0; fin = 0;
    dlog.delete();
    for (int g = 0; g < 400 && !fin; g++) begin
      idx = m_pos - 2;
      rn  = !(m_din_ready() && idx == rst_at);
      dv  = !(m_din_ready() && idx == drop_at);
      step(rn, 1'b1, 8'(len), dv, first + 16'(idx));
      if (!started) begin
        if (DOUT == SOF_W) started = 1;
        else               idles++;
      end
      if (BUSY) dlog.push_back(DOUT);
      if (!rn || e_done || e_err) fin = 1;
    end
    if (!fin) check("frame_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int idl;
    int frames;
    logic rn, sv, dv;
    logic [7:0] ln;

    // Reset with START_VALID already high.
    repeat (3) step(1'b0, 1'b1, 8'd2, 1'b0, 16'd0);
    check("reset_dout", DOUT, IDLE_W);

    // LEN=2 straight after reset release.
    run_frame(2, 16'h0001, -1, -1, idl);
    check("reset_gap_idles", 16'(idl), 16'(GAP));
    check("len2_size", 16'(dlog.size()), 16'd5);
    check("len2_sof", logw(0), SOF_W);
    check("len2_hdr", logw(1), 16'hFD02);
    check("len2_w0", logw(2), 16'h0001);
    check("len2_w1", logw(3), 16'h0002);
`ifndef SERIAL_FRAMER_CRC_EN
    check("len2_trl", logw(4), 16'hFD05);
`endif

    // Two back-to-back LEN=1 frames.
    run_frame(1, 16'h1234, -1, -1, idl);
    check("b2b_first_idles", 16'(idl), 16'(GAP));
    run_frame(1, 16'h4321, -1, -1, idl);
    check("b2b_second_idles", 16'(idl), 16'(GAP));

    // LEN=3 with an underrun on the second payload word.
    run_frame(3, 16'h0001, 1, -1, idl);
    check("abort_size", 16'(dlog.size()), 16'd4);
    check("abort_hdr", logw(1), 16'hFC03);
    check("abort_w0", logw(2), 16'h0001);
    check("abort_word", logw(3), ABORT_W);

    // LEN=0 after the abort: header goes straight to trailer.
    run_frame(0, 16'h0000, -1, -1, idl);
    check("after_abort_idles", 16'(idl), 16'(GAP));
    check("len0_size", 16'(dlog.size()), 16'd3);
    check("len0_hdr", logw(1), 16'hFF00);
`ifndef SERIAL_FRAMER_CRC_EN
    check("len0_trl", logw(2), 16'hFF00);
`endif

    // Reset in the middle of the payload.
    run_frame(5, 16'h0001, -1, 2, idl);
    check("rst_mid_dout", DOUT, IDLE_W);
    check("rst_mid_done", 16'(FRAME_DONE), 16'd0);

    // LEN=1 with a zero payload word after the mid-frame reset.
    run_frame(1, 16'h0000, -1, -1, idl);
    check("after_rst_idles", 16'(idl), 16'(GAP));
    check("len1_zero_size", 16'(dlog.size()), 16'd4);

    // Randomized traffic, including underruns and sporadic resets.
    frames = 0;
    for (int cyc = 0; cyc < 30000 && frames < 100; cyc++) begin
      rn = ($urandom_range(0, 299) != 0);
      sv = ($urandom_range(0, 3) != 0);
      dv = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 7) == 0) ln = 8'($urandom_range(0, 255));
      else                           ln = 8'($urandom_range(0, 16));
      step(rn, sv, ln, dv, 16'($urandom));
      if (e_done || e_err) frames++;
    end
    check("random_frames_done", 16'(frames >= 100), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
